mw_store_ctrl: RTL and testbench

- Sequences memory-stage stores into the data-cache write port.
- Takes one valid store request (address, data, size) from the MW stage and issues byte-masked, dword-aligned write transactions with a req/ack handshake.
- Splits a store that crosses a 4-byte boundary into two back-to-back transactions.
- Returns a one-cycle write_finished pulse; the MW stage uses it to release its stall.

---
 rtl/mw_store_ctrl_if.sv | 37 +++
 rtl/mw_store_ctrl.sv | 152 +++++++++++++++
 tb/tb_mw_store_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mw_store_ctrl_if.sv
// mw_store_ctrl_if
// Bundles the two sides of the store sequencer into one interface:
//   - Store request from the MW stage: st_req, st_addr, st_data, st_size.
//   - Data-cache write port: mem_req, mem_addr, mem_data, mem_be, mem_ack.
//   - Status back to the MW stage: write_finished, busy, split, fault.
// Modports:
//   master - the store controller view (drives mem_* and status).
//   slave  - the environment view (MW stage plus cache; drives st_* and mem_ack).
interface mw_store_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              write_finished;
  logic              busy;
  logic              split;
  logic              fault;

  modport master (
    input  st_req, st_addr, st_data, st_size, mem_ack,
    output mem_req, mem_addr, mem_data, mem_be,
    output write_finished, busy, split, fault
  );

  modport slave (
    output st_req, st_addr, st_data, st_size, mem_ack,
    input  mem_req, mem_addr, mem_data, mem_be,
    input  write_finished, busy, split, fault
  );
endinterface

// File: rtl/mw_store_ctrl.sv
// mw_store_ctrl
// Sequences one MW-stage store into byte-masked, dword-aligned cache write
// transactions with a req/ack handshake. A store whose bytes run past lane 3
// is issued as two back-to-back transactions (second one at address + 4,
// wrapping). A one-cycle write_finished pulse marks completion.
// Ports:
//   clk    - clock, rising edge.
//   reset  - asynchronous, active-high reset.
//   st_bus - mw_store_ctrl_if.master: st_* request in, mem_* write port out,
//            mem_ack in, write_finished/busy/split/fault status out.
// Optional feature: define MW_STORE_WDT_EN to add an ack watchdog that aborts
// a transaction after TIMEOUT cycles without mem_ack and raises fault.
// Without it a missing ack waits forever and fault is tied low.
module mw_store_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  mw_store_ctrl_if.master st_bus
);

  typedef enum logic [1:0] {IDLE, XFER1, XFER2, DONE} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t            r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_data;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_data_hi;
  logic [3:0]        r_be_hi;
  logic              r_wf;
  logic              r_busy;
  logic              r_split;
  logic              r_fault;

  logic [3:0]        w_mask;
  logic [7:0]        w_be_full;
  logic [63:0]       w_data_full;
  logic              w_cross;

  // Shifting the size mask and data into an 8-lane / 64-bit window gives both
  // transactions at once: the low half is the first dword, the high half is
  // whatever spilled into the next dword.
  always_comb begin
    w_mask = 4'b1111;
    case (st_bus.st_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_be_full   = {4'b0000, w_mask} << st_bus.st_addr[1:0];
  assign w_data_full = {32'd0, st_bus.st_data} << {st_bus.st_addr[1:0], 3'b000};
  assign w_cross     = |w_be_full[7:4];

`ifdef MW_STORE_WDT_EN
  logic [7:0] r_wdt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^LP_TIMEOUT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_be   <= '0;
      r_data_hi  <= '0;
      r_be_hi    <= '0;
      r_wf       <= 1'b0;
      r_busy     <= 1'b0;
      r_split    <= 1'b0;
      r_fault    <= 1'b0;
`ifdef MW_STORE_WDT_EN
      r_wdt      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (st_bus.st_req) begin
            r_state    <= XFER1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {st_bus.st_addr[ADDR_W-1:2], 2'b00};
            r_mem_be   <= w_be_full[3:0];
            r_mem_data <= w_data_full[31:0];
            r_be_hi    <= w_be_full[7:4];
            r_data_hi  <= w_data_full[63:32];
            r_split    <= w_cross;
            r_busy     <= 1'b1;
            r_fault    <= 1'b0;
`ifdef MW_STORE_WDT_EN
            r_wdt      <= '0;
`endif
          end
        end
        XFER1, XFER2: begin
          if (st_bus.mem_ack) begin
            if (r_state == XFER1 && r_split) begin
              // mem_req stays high: second transaction follows with no gap.
              r_state    <= XFER2;
              r_mem_addr <= r_mem_addr + ADDR_W'(4);
              r_mem_be   <= r_be_hi;
              r_mem_data <= r_data_hi;
`ifdef MW_STORE_WDT_EN
              r_wdt      <= '0;
`endif
            end else begin
              r_state   <= DONE;
              r_mem_req <= 1'b0;
              r_wf      <= 1'b1;
            end
          end
`ifdef MW_STORE_WDT_EN
          else if (r_wdt + 8'd1 == LP_TIMEOUT) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_wf      <= 1'b1;
            r_fault   <= 1'b1;
          end else begin
            r_wdt <= r_wdt + 8'd1;
          end
`endif
        end
        DONE: begin
          // Returning to IDLE for one cycle keeps a still-held st_req from
          // being taken as a new store.
          r_state <= IDLE;
          r_wf    <= 1'b0;
          r_busy  <= 1'b0;
          r_split <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign st_bus.mem_req        = r_mem_req;
  assign st_bus.mem_addr       = r_mem_addr;
  assign st_bus.mem_data       = r_mem_data;
  assign st_bus.mem_be         = r_mem_be;
  assign st_bus.write_finished = r_wf;
  assign st_bus.busy           = r_busy;
  assign st_bus.split          = r_split;
  assign st_bus.fault          = r_fault;

endmodule

// File: tb/tb_mw_store_ctrl.sv
// tb_mw_store_ctrl
// Drives directed and random stores into mw_store_ctrl and compares each
// write transaction against a byte-by-byte reference model.
module tb_mw_store_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mw_store_ctrl_if #(.ADDR_W(32)) bus_if ();

  mw_store_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .st_bus (bus_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected transactions of the current store.
  int          m_nt;
  logic [31:0] m_addr [2];
  logic [3:0]  m_be   [2];
  logic [31:0] m_data [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks the store one byte at a time and groups bytes by dword address.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int nb;
    logic [31:0] ba;
    logic [31:0] dw;
    int lane;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    m_nt = 0;
    for (int i = 0; i < nb; i++) begin
      ba   = a + 32'(i);
      dw   = ba & 32'hFFFF_FFFC;
      lane = int'(ba[1:0]);
      if (m_nt == 0 || m_addr[m_nt-1] != dw) begin
        m_addr[m_nt] = dw;
        m_be[m_nt]   = 4'b0000;
        m_data[m_nt] = 32'd0;
        m_nt++;
      end
      m_be[m_nt-1][lane] = 1'b1;
      m_data[m_nt-1][lane*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Called at posedge+1; returns at posedge+1 in the idle cycle after DONE.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int wmin, input int wmax, input bit scramble);
    int  k;
    int  wcnt;
    int  wtarget;
    int  cyc;
    int  total_w;
    bit  done;
    logic [31:0] got_d;
    model(a, d, sz);
    bus_if.st_req  = 1'b1;
    bus_if.st_addr = a;
    bus_if.st_data = d;
    bus_if.st_size = sz;
    k = 0; wcnt = 0; cyc = 0; total_w = 0; done = 0;
    wtarget = int'($urandom_range(wmax, wmin));
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus_if.mem_ack = 1'b0;
      if (scramble) begin
        bus_if.st_addr = $urandom;
        bus_if.st_data = $urandom;
        bus_if.st_size = 2'($urandom_range(3, 0));
      end
      if (bus_if.write_finished) begin
        check_val("xact_count", 64'(k), 64'(m_nt));
        check_val("latency", 64'(cyc), 64'(m_nt + 1 + total_w));
        check_val("split_done", 64'(bus_if.split), 64'(m_nt == 2));
        check_val("fault_clear", 64'(bus_if.fault), 64'd0);
        check_val("req_done", 64'(bus_if.mem_req), 64'd0);
        bus_if.st_req = 1'b0;
        done = 1;
      end else begin
        check_val("req_hold", 64'(bus_if.mem_req), 64'd1);
        check_val("busy", 64'(bus_if.busy), 64'd1);
        check_val("split", 64'(bus_if.split), 64'(m_nt == 2));
        if (bus_if.mem_req) begin
          if (k >= m_nt) begin
            check_val("extra_xact", 64'(k), 64'(m_nt - 1));
          end else begin
            got_d = bus_if.mem_data & lane_mask(m_be[k]);
            check_val("mem_addr", 64'(bus_if.mem_addr), 64'(m_addr[k]));
            check_val("mem_be", 64'(bus_if.mem_be), 64'(m_be[k]));
            check_val("mem_data", 64'(got_d), 64'(m_data[k]));
          end
          if (wcnt == wtarget) begin
            bus_if.mem_ack = 1'b1;
            k++;
            total_w += wtarget;
            wcnt = 0;
            wtarget = int'($urandom_range(wmax, wmin));
          end else begin
            wcnt++;
          end
        end
      end
    end
    if (!done) begin
      check_val("wf_timeout", 64'd0, 64'd1);
      bus_if.st_req  = 1'b0;
      bus_if.mem_ack = 1'b0;
    end
    @(posedge clk); #1;
    check_val("wf_pulse", 64'(bus_if.write_finished), 64'd0);
    check_val("idle_busy", 64'(bus_if.busy), 64'd0);
    check_val("idle_req", 64'(bus_if.mem_req), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          reqc;
    bit          seen_wf;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.st_req  = 1'b0;
    bus_if.st_addr = '0;
    bus_if.st_data = '0;
    bus_if.st_size = '0;
    bus_if.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 64'(bus_if.mem_req), 64'd0);
    check_val("rst_addr", 64'(bus_if.mem_addr), 64'd0);
    check_val("rst_data", 64'(bus_if.mem_data), 64'd0);
    check_val("rst_be", 64'(bus_if.mem_be), 64'd0);
    check_val("rst_wf", 64'(bus_if.write_finished), 64'd0);
    check_val("rst_busy", 64'(bus_if.busy), 64'd0);
    check_val("rst_split", 64'(bus_if.split), 64'd0);
    check_val("rst_fault", 64'(bus_if.fault), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_store(32'h0000_1000, 32'hAABB_CCDD, 2'b10, 0, 0, 0);
    do_store(32'h0000_2003, 32'h0000_00EE, 2'b00, 0, 1, 0);
    do_store(32'h0000_3002, 32'h1122_3344, 2'b10, 2, 2, 0);
    do_store(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 0, 1, 1);

    // Reset while waiting in the second transaction.
    bus_if.st_req  = 1'b1;
    bus_if.st_addr = 32'h0000_3002;
    bus_if.st_data = 32'h1122_3344;
    bus_if.st_size = 2'b10;
    @(posedge clk); #1;
    check_val("rm_x1_req", 64'(bus_if.mem_req), 64'd1);
    bus_if.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_ack = 1'b0;
    check_val("rm_x2_addr", 64'(bus_if.mem_addr), 64'h3004);
    check_val("rm_x2_be", 64'(bus_if.mem_be), 64'b0011);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("rm_req", 64'(bus_if.mem_req), 64'd0);
    check_val("rm_busy", 64'(bus_if.busy), 64'd0);
    check_val("rm_split", 64'(bus_if.split), 64'd0);
    check_val("rm_wf", 64'(bus_if.write_finished), 64'd0);
    bus_if.st_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rm_post_wf", 64'(bus_if.write_finished), 64'd0);
    check_val("rm_post_busy", 64'(bus_if.busy), 64'd0);
    do_store(32'h0000_5001, 32'hCAFE_F00D, 2'b01, 0, 2, 0);

`ifdef MW_STORE_WDT_EN
    // Watchdog: never acknowledge.
    bus_if.st_req  = 1'b1;
    bus_if.st_addr = 32'h0000_4000;
    bus_if.st_data = 32'h1234_5678;
    bus_if.st_size = 2'b10;
    reqc = 0;
    seen_wf = 0;
    for (int c = 0; c < 20 && !seen_wf; c++) begin
      @(posedge clk); #1;
      if (bus_if.mem_req) reqc++;
      if (bus_if.write_finished) begin
        seen_wf = 1;
        check_val("wdt_req_cycles", 64'(reqc), 64'd4);
        check_val("wdt_fault", 64'(bus_if.fault), 64'd1);
        bus_if.st_req = 1'b0;
      end
    end
    check_val("wdt_wf_seen", 64'(seen_wf), 64'd1);
    bus_if.st_req = 1'b0;
    @(posedge clk); #1;
    check_val("wdt_fault_hold", 64'(bus_if.fault), 64'd1);
    do_store(32'h0000_4004, 32'h0000_0077, 2'b00, 0, 0, 0);
`else
    reqc = 0;
    seen_wf = 0;
`endif

    // Random stores, biased toward dword-crossing and wrap addresses.
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      if ($urandom_range(3, 0) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
      rd = $urandom;
      rs = 2'($urandom_range(3, 0));
      do_store(ra, rd, rs, 0, 2, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
